// File: rtl/mem_access_pkg.sv
// Shared definitions for the memory access unit: op encodings, FSM states,
// default widths and request-decode helpers.
package mem_access_pkg;

  localparam int ADDR_W_DEF = 10;
  localparam int DATA_W_DEF = 16;

  localparam logic [2:0] OP_LW  = 3'b000;
  localparam logic [2:0] OP_LB  = 3'b001;
  localparam logic [2:0] OP_LBU = 3'b010;
  localparam logic [2:0] OP_SW  = 3'b100;
  localparam logic [2:0] OP_SB  = 3'b101;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_READ      = 3'd1,
    ST_WRITE     = 3'd2,
    ST_RMW_READ  = 3'd3,
    ST_RMW_WRITE = 3'd4,
    ST_RESP      = 3'd5
  } state_e;

  function automatic logic op_is_load(input logic [2:0] op);
    return (op == OP_LW) || (op == OP_LB) || (op == OP_LBU);
  endfunction

  // Word ops need an even byte address; unknown encodings are always rejected.
  function automatic logic op_is_err(input logic [2:0] op, input logic lane);
    logic err;
    case (op)
      OP_LW, OP_SW:         err = lane;
      OP_LB, OP_LBU, OP_SB: err = 1'b0;
      default:              err = 1'b1;
    endcase
    return err;
  endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Request/response handshake plus data-memory bus of the memory access unit.
// slave = the unit itself, master = requester and memory side.
interface mem_access_unit_if
  import mem_access_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
);

  logic              req_valid;
  logic              req_ready;
  logic [2:0]        req_op;
  logic [ADDR_W:0]   req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              resp_valid;
  logic [DATA_W-1:0] resp_rdata;
  logic              resp_err;
  logic              mem_load;
  logic              mem_store;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  req_valid, req_op, req_addr, req_wdata, mem_rdata,
    output req_ready, resp_valid, resp_rdata, resp_err,
           mem_load, mem_store, mem_addr, mem_wdata
  );

  modport master (
    output req_valid, req_op, req_addr, req_wdata, mem_rdata,
    input  req_ready, resp_valid, resp_rdata, resp_err,
           mem_load, mem_store, mem_addr, mem_wdata
  );

endinterface

// File: rtl/mem_access_unit_byte_lane_merge.sv
// Combinational byte-lane helper: extracts/extends a load byte and merges a
// store byte into a word (little-endian lanes).
module byte_lane_merge
  import mem_access_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic [DATA_W-1:0] ext_word,
  input  logic              ext_lane,
  input  logic              ext_byte,
  input  logic              ext_signed,
  output logic [DATA_W-1:0] ext_data,
  input  logic [DATA_W-1:0] merge_word,
  input  logic              merge_lane,
  input  logic [7:0]        merge_byte,
  output logic [DATA_W-1:0] merge_data
);

  logic [7:0] sel_byte_s;

  // Load path: pick the lane, then sign- or zero-extend it.
  always_comb begin
    sel_byte_s = ext_lane ? ext_word[15:8] : ext_word[7:0];
    if (!ext_byte) begin
      ext_data = ext_word;
    end else if (ext_signed) begin
      ext_data = {{(DATA_W-8){sel_byte_s[7]}}, sel_byte_s};
    end else begin
      ext_data = {{(DATA_W-8){1'b0}}, sel_byte_s};
    end
  end

  // Store path: replace only the addressed byte.
  always_comb begin
    merge_data = merge_word;
    if (merge_lane) begin
      merge_data[DATA_W-1:8] = merge_byte;
    end else begin
      merge_data[7:0] = merge_byte;
    end
  end

endmodule

// File: rtl/mem_access_unit.sv
// Memory access unit: one LW/LB/LBU/SW/SB request at a time onto a word memory.
// Optional last-word cache is built when LAST_WORD_CACHE_EN is defined.
module mem_access_unit
  import mem_access_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  mem_access_unit_if.slave bus
);

  state_e            state_r, state_nxt_s;
  logic [2:0]        op_r;
  logic [ADDR_W:0]   addr_r;
  logic [DATA_W-1:0] wdata_r, word_r, resp_rdata_r;
  logic              resp_err_r;
  logic              accept_s, req_err_s, req_load_s, cache_hit_s;
  logic [DATA_W-1:0] cache_word_s, ext_word_s, ext_data_s, merge_data_s, rdata_nxt_s;
  logic              ext_lane_s, ext_byte_s, ext_signed_s, err_nxt_s;
  logic [ADDR_W-1:0] word_addr_s;
  logic              mem_load_s, mem_store_s;
  logic [ADDR_W-1:0] mem_addr_s;
  logic [DATA_W-1:0] mem_wdata_s;

  assign accept_s    = bus.req_valid && (state_r == ST_IDLE);
  assign req_err_s   = op_is_err(bus.req_op, bus.req_addr[0]);
  assign req_load_s  = op_is_load(bus.req_op);
  assign word_addr_s = addr_r[ADDR_W:1];

`ifdef LAST_WORD_CACHE_EN
  logic              cache_valid_r;
  logic [ADDR_W-1:0] cache_addr_r;
  logic [DATA_W-1:0] cache_word_r;

  assign cache_hit_s  = cache_valid_r && (cache_addr_r == bus.req_addr[ADDR_W:1]);
  assign cache_word_s = cache_word_r;

  // Track the last word moved over the memory bus; this unit is the only writer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cache_valid_r <= 1'b0;
      cache_addr_r  <= {ADDR_W{1'b0}};
      cache_word_r  <= {DATA_W{1'b0}};
    end else begin
      case (state_r)
        ST_READ, ST_RMW_READ: begin
          cache_valid_r <= 1'b1;
          cache_addr_r  <= word_addr_s;
          cache_word_r  <= bus.mem_rdata;
        end
        ST_WRITE: begin
          cache_valid_r <= 1'b1;
          cache_addr_r  <= word_addr_s;
          cache_word_r  <= wdata_r;
        end
        ST_RMW_WRITE: begin
          cache_valid_r <= 1'b1;
          cache_addr_r  <= word_addr_s;
          cache_word_r  <= merge_data_s;
        end
        default: begin
          cache_valid_r <= cache_valid_r;
          cache_addr_r  <= cache_addr_r;
          cache_word_r  <= cache_word_r;
        end
      endcase
    end
  end
`else
  assign cache_hit_s  = 1'b0;
  assign cache_word_s = {DATA_W{1'b0}};
`endif

  byte_lane_merge #(.DATA_W(DATA_W)) u_byte_lane_merge (
    .ext_word   (ext_word_s),
    .ext_lane   (ext_lane_s),
    .ext_byte   (ext_byte_s),
    .ext_signed (ext_signed_s),
    .ext_data   (ext_data_s),
    .merge_word (word_r),
    .merge_lane (addr_r[0]),
    .merge_byte (wdata_r[7:0]),
    .merge_data (merge_data_s)
  );

  // Load extraction source: memory in READ, cached word on a hit at accept time.
  always_comb begin
    if (state_r == ST_READ) begin
      ext_word_s   = bus.mem_rdata;
      ext_lane_s   = addr_r[0];
      ext_byte_s   = (op_r != OP_LW);
      ext_signed_s = (op_r == OP_LB);
    end else begin
      ext_word_s   = cache_word_s;
      ext_lane_s   = bus.req_addr[0];
      ext_byte_s   = (bus.req_op != OP_LW);
      ext_signed_s = (bus.req_op == OP_LB);
    end
  end

  // Next-state decode.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (!accept_s) begin
          state_nxt_s = ST_IDLE;
        end else if (req_err_s) begin
          state_nxt_s = ST_RESP;
        end else if (req_load_s) begin
          state_nxt_s = cache_hit_s ? ST_RESP : ST_READ;
        end else if (bus.req_op == OP_SW) begin
          state_nxt_s = ST_WRITE;
        end else begin
          state_nxt_s = cache_hit_s ? ST_RMW_WRITE : ST_RMW_READ;
        end
      end
      ST_READ:      state_nxt_s = ST_RESP;
      ST_WRITE:     state_nxt_s = ST_RESP;
      ST_RMW_READ:  state_nxt_s = ST_RMW_WRITE;
      ST_RMW_WRITE: state_nxt_s = ST_RESP;
      ST_RESP:      state_nxt_s = ST_IDLE;
      default:      state_nxt_s = ST_IDLE;
    endcase
  end

  // Response payload for the following cycle; zero unless entering RESP with data.
  always_comb begin
    rdata_nxt_s = {DATA_W{1'b0}};
    err_nxt_s   = 1'b0;
    if (state_r == ST_READ) begin
      rdata_nxt_s = ext_data_s;
    end else if (accept_s && req_err_s) begin
      err_nxt_s = 1'b1;
    end else if (accept_s && req_load_s && cache_hit_s) begin
      rdata_nxt_s = ext_data_s;
    end else begin
      rdata_nxt_s = {DATA_W{1'b0}};
      err_nxt_s   = 1'b0;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Request latch, captured memory word and registered response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_r         <= 3'b000;
      addr_r       <= {(ADDR_W+1){1'b0}};
      wdata_r      <= {DATA_W{1'b0}};
      word_r       <= {DATA_W{1'b0}};
      resp_rdata_r <= {DATA_W{1'b0}};
      resp_err_r   <= 1'b0;
    end else begin
      resp_rdata_r <= rdata_nxt_s;
      resp_err_r   <= err_nxt_s;
      if (accept_s) begin
        op_r    <= bus.req_op;
        addr_r  <= bus.req_addr;
        wdata_r <= bus.req_wdata;
        word_r  <= cache_word_s;
      end else if (state_r == ST_RMW_READ) begin
        word_r <= bus.mem_rdata;
      end else begin
        word_r <= word_r;
      end
    end
  end

  // Memory strobes come from the state register alone.
  always_comb begin
    mem_load_s  = 1'b0;
    mem_store_s = 1'b0;
    mem_addr_s  = {ADDR_W{1'b0}};
    mem_wdata_s = {DATA_W{1'b0}};
    case (state_r)
      ST_READ, ST_RMW_READ: begin
        mem_load_s = 1'b1;
        mem_addr_s = word_addr_s;
      end
      ST_WRITE: begin
        mem_store_s = 1'b1;
        mem_addr_s  = word_addr_s;
        mem_wdata_s = wdata_r;
      end
      ST_RMW_WRITE: begin
        mem_store_s = 1'b1;
        mem_addr_s  = word_addr_s;
        mem_wdata_s = merge_data_s;
      end
      default: begin
        mem_load_s  = 1'b0;
        mem_store_s = 1'b0;
      end
    endcase
  end

  assign bus.req_ready  = (state_r == ST_IDLE);
  assign bus.resp_valid = (state_r == ST_RESP);
  assign bus.resp_rdata = resp_rdata_r;
  assign bus.resp_err   = resp_err_r;
  assign bus.mem_load   = mem_load_s;
  assign bus.mem_store  = mem_store_s;
  assign bus.mem_addr   = mem_addr_s;
  assign bus.mem_wdata  = mem_wdata_s;

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: reference model of memory and response
// timing plus directed literal checks. Honours LAST_WORD_CACHE_EN for latencies.
module tb_mem_access_unit;
  import mem_access_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  mem_access_unit_if #(.ADDR_W(10), .DATA_W(16)) bus ();
  mem_access_unit #(.ADDR_W(10), .DATA_W(16)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

`ifdef LAST_WORD_CACHE_EN
  localparam int LAT_LW_HIT = 1;
  localparam int LAT_SB_HIT = 2;
`else
  localparam int LAT_LW_HIT = 2;
  localparam int LAT_SB_HIT = 3;
`endif

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int last_due = 0;
  int n_acc = 0;
  int n_dut_resp = 0;

  logic [15:0] tb_mem [0:1023];
  logic [15:0] ref_mem [0:1023];
  assign bus.mem_rdata = tb_mem[bus.mem_addr];

  // data memory driven by the DUT
  always @(posedge clk) if (bus.mem_store) tb_mem[bus.mem_addr] <= bus.mem_wdata;

  typedef struct {
    int          due;
    int          load_cyc;
    int          store_cyc;
    logic [15:0] rdata;
    logic        err;
    logic [2:0]  op;
    logic [9:0]  waddr;
    logic        lane;
    logic [15:0] wdata;
  } exp_t;
  exp_t exp_q[$];
  logic m_cv = 1'b0;
  logic [9:0] m_ca = 10'd0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] model_merge(input logic [15:0] w, input logic lane, input logic [7:0] b);
    logic [15:0] r;
    r = w;
    if (lane) r[15:8] = b; else r[7:0] = b;
    return r;
  endfunction

  // model: accept, latency, result and store commit per the unit's rules
  always @(posedge clk) begin
    exp_t e;
    logic [15:0] w;
    logic [7:0]  b;
    logic        hit, acc;
    int          lat;
    acc = rst_n && bus.req_valid && (exp_q.size() == 0) && (cyc > last_due);
    cyc = cyc + 1;
    if (rst_n && exp_q.size() > 0 && exp_q[0].store_cyc >= 0 && cyc == exp_q[0].due)
      ref_mem[exp_q[0].waddr] = (exp_q[0].op == OP_SW) ? exp_q[0].wdata
                              : model_merge(ref_mem[exp_q[0].waddr], exp_q[0].lane, exp_q[0].wdata[7:0]);
    if (acc) begin
      e.op = bus.req_op; e.waddr = bus.req_addr[10:1]; e.lane = bus.req_addr[0];
      e.wdata = bus.req_wdata; e.rdata = 16'h0000; e.load_cyc = -1; e.store_cyc = -1;
      e.err = !(e.op inside {OP_LW, OP_LB, OP_LBU, OP_SW, OP_SB}) ||
              ((e.op == OP_LW || e.op == OP_SW) && e.lane);
`ifdef LAST_WORD_CACHE_EN
      hit = m_cv && (m_ca == e.waddr);
`else
      hit = 1'b0;
`endif
      w = ref_mem[e.waddr];
      b = e.lane ? w[15:8] : w[7:0];
      if (e.err) lat = 1;
      else if (e.op == OP_SW) lat = 2;
      else if (e.op == OP_SB) lat = hit ? 2 : 3;
      else lat = hit ? 1 : 2;
      e.due = cyc + lat - 1;
      if (!e.err) begin
        m_cv = 1'b1; m_ca = e.waddr;
        if (e.op == OP_LW) e.rdata = w;
        else if (e.op == OP_LB) e.rdata = {{8{b[7]}}, b};
        else if (e.op == OP_LBU) e.rdata = {8'h00, b};
        if ((e.op == OP_LW || e.op == OP_LB || e.op == OP_LBU) && !hit) e.load_cyc = e.due - 1;
        if (e.op == OP_SW || e.op == OP_SB) e.store_cyc = e.due - 1;
        if (e.op == OP_SB && !hit) e.load_cyc = e.due - 2;
      end
      exp_q.push_back(e);
      last_due = e.due;
      n_acc++;
    end
  end

  always @(negedge rst_n) begin
    exp_q.delete();
    last_due = cyc;
    m_cv = 1'b0;
  end

  // compare every cycle against the model
  always @(negedge clk) begin
    exp_t e;
    logic [15:0] e_rd, e_mwd;
    logic [9:0]  e_ma;
    logic        e_rv, e_err, e_ld, e_st, e_rdy;
    e_rd = 16'h0000; e_mwd = 16'h0000; e_ma = 10'd0;
    e_rv = 1'b0; e_err = 1'b0; e_ld = 1'b0; e_st = 1'b0;
    e_rdy = rst_n ? ((exp_q.size() == 0) && (cyc > last_due)) : 1'b1;
    if (rst_n && exp_q.size() > 0) begin
      e = exp_q[0];
      if (cyc == e.due) begin e_rv = 1'b1; e_rd = e.rdata; e_err = e.err; end
      if (cyc == e.load_cyc) begin e_ld = 1'b1; e_ma = e.waddr; end
      if (cyc == e.store_cyc) begin
        e_st = 1'b1; e_ma = e.waddr;
        e_mwd = (e.op == OP_SW) ? e.wdata : model_merge(ref_mem[e.waddr], e.lane, e.wdata[7:0]);
      end
    end
    chk("resp_valid", bus.resp_valid, e_rv);
    chk("resp_rdata", bus.resp_rdata, e_rd);
    chk("resp_err", bus.resp_err, e_err);
    chk("req_ready", bus.req_ready, e_rdy);
    chk("mem_load", bus.mem_load, e_ld);
    chk("mem_store", bus.mem_store, e_st);
    chk("mem_addr", bus.mem_addr, e_ma);
    chk("mem_wdata", bus.mem_wdata, e_mwd);
    if (bus.resp_valid) n_dut_resp++;
    if (exp_q.size() > 0 && cyc >= exp_q[0].due) void'(exp_q.pop_front());
  end

  logic [15:0] last_rdata;
  logic        last_err;
  int          last_lat;

  task automatic do_req(input logic [2:0] op, input logic [10:0] addr, input logic [15:0] wd);
    int w;
    @(posedge clk); #2;
    bus.req_valid = 1'b1; bus.req_op = op; bus.req_addr = addr; bus.req_wdata = wd;
    w = 0;
    while (!bus.req_ready && w < 20) begin @(posedge clk); #2; w++; end
    chk("req_accept", bus.req_ready, 1'b1);
    @(posedge clk); #2;
    bus.req_valid = 1'b0;
    last_lat = 0; last_rdata = 16'hxxxx; last_err = 1'bx;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (bus.resp_valid) begin
        last_lat = k; last_rdata = bus.resp_rdata; last_err = bus.resp_err;
        break;
      end
    end
    chk("resp_seen", (last_lat != 0), 1'b1);
  endtask

  logic [2:0]  b_op   [7] = '{OP_SW, OP_LB, OP_SB, OP_LW, 3'b110, OP_LBU, OP_SW};
  logic [10:0] b_addr [7] = '{11'h010, 11'h011, 11'h010, 11'h010, 11'h010, 11'h010, 11'h013};
  logic [15:0] b_wd   [7] = '{16'hA55A, 16'h0000, 16'h007F, 16'h0000, 16'h0000, 16'h0000, 16'h1111};

  initial begin
    #200000;
    $display("FAIL watchdog: actual timeout required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int w, acc0, dr0, mm, rs;
    rst_n = 1'b0;
    bus.req_valid = 1'b0; bus.req_op = 3'b000; bus.req_addr = 11'd0; bus.req_wdata = 16'h0000;
    for (int i = 0; i < 1024; i++) begin tb_mem[i] <= 16'h0000; ref_mem[i] = 16'h0000; end
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    chk("reset_req_ready", bus.req_ready, 1'b1);
    chk("reset_resp_valid", bus.resp_valid, 1'b0);
    chk("reset_mem_store", bus.mem_store, 1'b0);

    do_req(OP_SW, 11'h00A, 16'hBEEF);
    chk("sw_lat", last_lat, 32'd2);
    chk("sw_mem5", tb_mem[5], 16'hBEEF);
    do_req(OP_LW, 11'h00A, 16'h0000);
    chk("lw_data", last_rdata, 16'hBEEF);
    chk("lw_lat", last_lat, LAT_LW_HIT);
    do_req(OP_LB, 11'h00B, 16'h0000);
    chk("lb_hi", last_rdata, 16'hFFBE);
    do_req(OP_LBU, 11'h00B, 16'h0000);
    chk("lbu_hi", last_rdata, 16'h00BE);
    do_req(OP_LB, 11'h00A, 16'h0000);
    chk("lb_lo", last_rdata, 16'hFFEF);
    do_req(OP_SB, 11'h00B, 16'h0012);
    chk("sb_mem5", tb_mem[5], 16'h12EF);
    chk("sb_lat", last_lat, LAT_SB_HIT);
    chk("sb_rdata", last_rdata, 16'h0000);
    do_req(OP_LW, 11'h00B, 16'h0000);
    chk("lw_odd_err", last_err, 1'b1);
    chk("lw_odd_lat", last_lat, 32'd1);
    chk("lw_odd_rdata", last_rdata, 16'h0000);
    do_req(3'b011, 11'h00A, 16'h0000);
    chk("illegal_err", last_err, 1'b1);
    chk("illegal_lat", last_lat, 32'd1);
    do_req(OP_LW, 11'h00A, 16'h0000);
    chk("lw_after_sb", last_rdata, 16'h12EF);

    // reset during WRITE must abort the store and the response
    tb_mem[2] <= 16'h5A5A; ref_mem[2] = 16'h5A5A;
    @(posedge clk); #2;
    bus.req_valid = 1'b1; bus.req_op = OP_SW; bus.req_addr = 11'h004; bus.req_wdata = 16'h1234;
    chk("rst_pre_ready", bus.req_ready, 1'b1);
    @(posedge clk); #2;
    bus.req_valid = 1'b0;
    chk("rst_in_write", bus.mem_store, 1'b1);
    rst_n = 1'b0;
    #1 chk("rst_store_forced", bus.mem_store, 1'b0);
    @(posedge clk); @(posedge clk); #2 rst_n = 1'b1;
    rs = 0;
    repeat (4) begin @(negedge clk); if (bus.resp_valid) rs = 1; end
    chk("rst_no_resp", rs, 32'd0);
    chk("rst_mem2", tb_mem[2], 16'h5A5A);
    chk("rst_ready_after", bus.req_ready, 1'b1);

    // back-to-back requests with req_valid held high
    acc0 = n_acc; dr0 = n_dut_resp;
    @(posedge clk); #2;
    bus.req_valid = 1'b1;
    for (int i = 0; i < 7; i++) begin
      bus.req_op = b_op[i]; bus.req_addr = b_addr[i]; bus.req_wdata = b_wd[i];
      w = 0;
      while (!bus.req_ready && w < 20) begin @(posedge clk); #2; w++; end
      chk("b2b_ready", bus.req_ready, 1'b1);
      @(posedge clk); #2;
    end
    bus.req_valid = 1'b0;
    repeat (8) @(negedge clk);
    chk("b2b_resp_count", n_dut_resp - dr0, 32'd7);
    chk("b2b_mem8", tb_mem[8], 16'hA57F);
    chk("b2b_model_acc", n_acc - acc0, n_dut_resp - dr0);

    mm = 0;
    for (int i = 0; i < 1024; i++) if (tb_mem[i] !== ref_mem[i]) mm++;
    chk("mem_image", mm, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
